lms_weight_update: RTL and testbench

- Consumes the error word E produced by the output-error stage and the matching input sample.
- Performs one LMS tap-weight update per accepted error: w[k] += mu*E*x[n-k].
- Holds the x delay line and the weight registers; the weights drive the FIR/carry-save multiply stage upstream.
- Uses one shared multiplier, iterated over the taps by an FSM.

---
 rtl/lms_weight_update.sv | 168 ++++++++++++++++
 tb/tb_lms_weight_update.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lms_weight_update.sv
// LMS tap-weight update engine.
// Accepts one (x, e) pair, shifts x into the delay line, then walks the taps with a single
// shared multiplier: w[k] <= sat(w[k] + ((e * x[n-k]) >>> (DW-1+MU_SHIFT))).
// Optional feature: define LEAKAGE_EN for leaky LMS,
//   w[k] <= sat(w[k] - (w[k] >>> LEAK_SHIFT) + delta).
// Without LEAKAGE_EN no leakage logic is built and LEAK_SHIFT only feeds a parameter check.
module lms_weight_update #(
  parameter int unsigned TAPS       = 4,
  parameter int unsigned DW         = 10,
  parameter int unsigned MU_SHIFT   = 6,
  parameter int unsigned LEAK_SHIFT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        x_in,
  input  logic [DW-1:0]        e_in,
  output logic [TAPS*DW-1:0]   w_flat,
  output logic                 upd_done,
  output logic                 busy,
  output logic                 sat
);

  localparam int unsigned KW    = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int unsigned PW    = 2 * DW;
  localparam int unsigned Shift = DW - 1 + MU_SHIFT;

  localparam logic [KW-1:0]        KLast = KW'(TAPS - 1);
  localparam logic signed [PW-1:0] WMax  = PW'((2 ** (DW - 1)) - 1);
  localparam logic signed [PW-1:0] WMin  = PW'(-(2 ** (DW - 1)));

  // Reject configurations that cannot work: a single tap, or a leak that clears weights.
  if (TAPS < 2 || LEAK_SHIFT == 0) begin : g_bad_params
    $error("lms_weight_update: need TAPS >= 2 and LEAK_SHIFT > 0");
  end

  typedef enum logic [1:0] {
    StIdle,
    StUpdate,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic signed [DW-1:0] x_dly_q [TAPS];
  logic signed [DW-1:0] w_q     [TAPS];
  logic signed [DW-1:0] e_lat_q;
  logic [KW-1:0]        k_q;
  logic                 sat_q;

  logic                 accept;
  logic signed [DW-1:0] x_sel;
  logic signed [DW-1:0] w_sel;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] delta;
  logic signed [PW-1:0] w_ext;
  logic signed [PW-1:0] sum;
  logic signed [DW-1:0] w_new;
  logic                 clamp;

  assign accept = in_valid & (state_q == StIdle);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: accept -> one cycle per tap -> one DONE cycle -> idle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (in_valid) state_d = StUpdate;
      StUpdate: if (k_q == KLast) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    upd_done = 1'b0;
    unique case (state_q)
      StIdle:   in_ready = 1'b1;
      StUpdate: busy     = 1'b1;
      StDone: begin
        busy     = 1'b1;
        upd_done = 1'b1;
      end
      default:  in_ready = 1'b0;
    endcase
  end

  // Shared multiply, step-size shift, optional leak and saturation for the current tap
  always_comb begin
    x_sel = x_dly_q[k_q];
    w_sel = w_q[k_q];
    prod  = PW'(e_lat_q) * PW'(x_sel);
    // Arithmetic shift floors toward -inf; no rounding bias is added on purpose.
    delta = prod >>> Shift;
    w_ext = PW'(w_sel);
`ifdef LEAKAGE_EN
    sum   = w_ext - (w_ext >>> LEAK_SHIFT) + delta;
`else
    sum   = w_ext + delta;
`endif
    clamp = 1'b0;
    if (sum > WMax) begin
      w_new = WMax[DW-1:0];
      clamp = 1'b1;
    end else if (sum < WMin) begin
      w_new = WMin[DW-1:0];
      clamp = 1'b1;
    end else begin
      w_new = sum[DW-1:0];
    end
  end

  // Delay line, latched error and tap counter; loaded only on an accepted pair
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        x_dly_q[i] <= '0;
      end
      e_lat_q <= '0;
      k_q     <= '0;
    end else if (accept) begin
      x_dly_q[0] <= x_in;
      for (int i = 1; i < TAPS; i++) begin
        x_dly_q[i] <= x_dly_q[i-1];
      end
      e_lat_q <= e_in;
      k_q     <= '0;
    end else if (state_q == StUpdate) begin
      k_q <= k_q + KW'(1);
    end
  end

  // Weight registers and sticky saturation flag; weights only move in UPDATE cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        w_q[i] <= '0;
      end
      sat_q <= 1'b0;
    end else if (state_q == StUpdate) begin
      w_q[k_q] <= w_new;
      sat_q    <= sat_q | clamp;
    end
  end

  // Flatten weights for the upstream multiply stage
  always_comb begin
    w_flat = '0;
    for (int i = 0; i < TAPS; i++) begin
      w_flat[i*DW +: DW] = w_q[i];
    end
  end

  assign sat = sat_q;

endmodule

// File: tb/tb_lms_weight_update.sv
// Directed self-checking bench for lms_weight_update (TAPS=4, DW=10, MU_SHIFT=6).
module tb_lms_weight_update;

  localparam int TAPS = 4;
  localparam int DW   = 10;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic [DW-1:0]        x_in = '0;
  logic [DW-1:0]        e_in = '0;
  logic                 in_ready;
  logic [TAPS*DW-1:0]   w_flat;
  logic                 upd_done;
  logic                 busy;
  logic                 sat;

  int vectors = 0;
  int miscompares = 0;

  lms_weight_update #(
    .TAPS      (TAPS),
    .DW        (DW),
    .MU_SHIFT  (6),
    .LEAK_SHIFT(8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .x_in    (x_in),
    .e_in    (e_in),
    .w_flat  (w_flat),
    .upd_done(upd_done),
    .busy    (busy),
    .sat     (sat)
  );

  always #5 clk = ~clk;

  function automatic logic [TAPS*DW-1:0] pack(input int w0, input int w1, input int w2,
                                              input int w3);
    return {10'(w3), 10'(w2), 10'(w1), 10'(w0)};
  endfunction

  // Leaves the bench at a falling edge with reset released.
  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One full update from a falling edge; returns on the falling edge of the idle cycle.
  task automatic run_update(input int x, input int e);
    int n;
    in_valid = 1'b1;
    x_in     = 10'(x);
    e_in     = 10'(e);
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (upd_done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (upd_done !== 1'b1) begin
      miscompares++;
      $display("FAIL run_update_done: upd_done=%b required 1 within 20 cycles", upd_done);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    vectors += 5;
    if (w_flat !== '0) begin
      miscompares++;
      $display("FAIL reset_w_flat: got %h required 0", w_flat);
    end
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy: got %b required 0", busy);
    end
    if (upd_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_upd_done: got %b required 0", upd_done);
    end
    if (sat !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_sat: got %b required 0", sat);
    end
  endtask

  // x=256, e=256 -> prod 65536 -> delta 2 on tap 0 only.
  task automatic test_basic();
    logic exp_done, exp_rdy, exp_busy;
    do_reset();
    in_valid = 1'b1;
    x_in     = 10'd256;
    e_in     = 10'd256;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_ready_c0: got %b required 1", in_ready);
    end
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) in_valid = 1'b0;
      exp_done = (c == 5);
      exp_rdy  = (c == 6);
      exp_busy = (c <= 5);
      vectors += 3;
      if (upd_done !== exp_done) begin
        miscompares++;
        $display("FAIL basic_upd_done c%0d: got %b required %b", c, upd_done, exp_done);
      end
      if (in_ready !== exp_rdy) begin
        miscompares++;
        $display("FAIL basic_in_ready c%0d: got %b required %b", c, in_ready, exp_rdy);
      end
      if (busy !== exp_busy) begin
        miscompares++;
        $display("FAIL basic_busy c%0d: got %b required %b", c, busy, exp_busy);
      end
      if (c == 1) begin
        vectors++;
        if (w_flat !== pack(0, 0, 0, 0)) begin
          miscompares++;
          $display("FAIL basic_w_c1: got %h required %h", w_flat, pack(0, 0, 0, 0));
        end
      end
      if (c == 2 || c == 6) begin
        vectors++;
        if (w_flat !== pack(2, 0, 0, 0)) begin
          miscompares++;
          $display("FAIL basic_w c%0d: got %h required %h", c, w_flat, pack(2, 0, 0, 0));
        end
      end
    end
  endtask

  // x=1, e=-1 -> prod -1 -> floor shift gives -1.
  task automatic test_trunc();
    do_reset();
    run_update(1, -1);
    vectors += 2;
    if (w_flat !== pack(-1, 0, 0, 0)) begin
      miscompares++;
      $display("FAIL trunc_w: got %h required %h", w_flat, pack(-1, 0, 0, 0));
    end
    if (sat !== 1'b0) begin
      miscompares++;
      $display("FAIL trunc_sat: got %b required 0", sat);
    end
  endtask

  // 511*511 = 261121 -> delta 7; tap k gets 7*(N-k) after N updates, clamped to 511.
  task automatic test_saturation();
    do_reset();
    repeat (73) run_update(511, 511);
    vectors += 2;
    if (w_flat !== pack(511, 504, 497, 490)) begin
      miscompares++;
      $display("FAIL sat73_w: got %h required %h", w_flat, pack(511, 504, 497, 490));
    end
    if (sat !== 1'b0) begin
      miscompares++;
      $display("FAIL sat73_flag: got %b required 0", sat);
    end
    run_update(511, 511);
    vectors += 2;
    if (w_flat !== pack(511, 511, 504, 497)) begin
      miscompares++;
      $display("FAIL sat74_w: got %h required %h", w_flat, pack(511, 511, 504, 497));
    end
    if (sat !== 1'b1) begin
      miscompares++;
      $display("FAIL sat74_flag: got %b required 1", sat);
    end
    run_update(0, 0);
    vectors += 2;
    if (w_flat !== pack(511, 511, 504, 497)) begin
      miscompares++;
      $display("FAIL sat_zero_w: got %h required %h", w_flat, pack(511, 511, 504, 497));
    end
    if (sat !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_sticky: got %b required 1", sat);
    end
  endtask

  // in_valid held high: accepts at cycles 0, 6, 12 only.
  task automatic test_back_to_back();
    int xs [3] = '{256, -256, 128};
    int es [3] = '{256, 256, -512};
    int idx, accepts, dones;
    logic acc, exp_rdy;
    do_reset();
    idx = 0;
    accepts = 0;
    dones = 0;
    in_valid = 1'b1;
    x_in = 10'(xs[0]);
    e_in = 10'(es[0]);
    for (int c = 0; c <= 17; c++) begin
      exp_rdy = (c % 6 == 0);
      vectors++;
      if (in_ready !== exp_rdy) begin
        miscompares++;
        $display("FAIL bp_in_ready c%0d: got %b required %b", c, in_ready, exp_rdy);
      end
      acc = (in_ready === 1'b1);
      if (acc) accepts++;
      if (upd_done === 1'b1) dones++;
      if (c == 17) in_valid = 1'b0;
      @(negedge clk);
      if (acc && idx < 2) begin
        idx++;
        x_in = 10'(xs[idx]);
        e_in = 10'(es[idx]);
      end
    end
    vectors += 4;
    if (accepts !== 3) begin
      miscompares++;
      $display("FAIL bp_accepts: got %0d required 3", accepts);
    end
    if (dones !== 3) begin
      miscompares++;
      $display("FAIL bp_done_pulses: got %0d required 3", dones);
    end
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_ready_end: got %b required 1", in_ready);
    end
    if (w_flat !== pack(-2, 6, -4, 0)) begin
      miscompares++;
      $display("FAIL bp_w: got %h required %h", w_flat, pack(-2, 6, -4, 0));
    end
  endtask

  task automatic test_reset_midop();
    logic seen;
    do_reset();
    run_update(256, 256);
    in_valid = 1'b1;
    x_in = 10'd256;
    e_in = 10'd256;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (w_flat !== pack(4, 0, 0, 0)) begin
      miscompares++;
      $display("FAIL midop_pre_w: got %h required %h", w_flat, pack(4, 0, 0, 0));
    end
    rst_n = 1'b0;
    #1;
    vectors += 3;
    if (w_flat !== '0) begin
      miscompares++;
      $display("FAIL midop_w_cleared: got %h required 0", w_flat);
    end
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midop_busy: got %b required 0", busy);
    end
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midop_ready_in_reset: got %b required 1", in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (upd_done !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    vectors += 3;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL midop_no_done: got %b required 0", seen);
    end
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midop_ready_after: got %b required 1", in_ready);
    end
    if (w_flat !== '0) begin
      miscompares++;
      $display("FAIL midop_w_after: got %h required 0", w_flat);
    end
  endtask

`ifdef LEAKAGE_EN
  task automatic test_leakage();
    do_reset();
    run_update(1, -1);
    run_update(0, 0);
    vectors++;
    if (w_flat[DW-1:0] !== 10'd0) begin
      miscompares++;
      $display("FAIL leak_neg1: got %h required 0", w_flat[DW-1:0]);
    end
    do_reset();
    repeat (128) run_update(256, 256);
    vectors++;
    if (w_flat[DW-1:0] !== 10'd256) begin
      miscompares++;
      $display("FAIL leak_build: got %0d required 256", w_flat[DW-1:0]);
    end
    run_update(0, 0);
    vectors++;
    if (w_flat[DW-1:0] !== 10'd255) begin
      miscompares++;
      $display("FAIL leak_256: got %0d required 255", w_flat[DW-1:0]);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_trunc();
`ifndef LEAKAGE_EN
    test_saturation();
`endif
    test_back_to_back();
    test_reset_midop();
`ifdef LEAKAGE_EN
    test_leakage();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
